// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_if
// Purpose  : Instruction-memory request/response bundle for the fetch stage.
// Revision : 1.0  initial release
// ============================================================================
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : IF stage with skid buffer, redirect handling and response drop.
// Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_rst,
    input  logic                   if_en,
    input  logic [2:0]             pc_src,
    input  logic [31:0]            fwd_rs_data,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            inst_id,
    output logic [31:0]            pc_id,
    output logic                   if_valid,
    output logic                   fetch_stall
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [2:0] C_PC_JUMP     = 3'd1;
    localparam logic [2:0] C_PC_BRANCH   = 3'd2;
    localparam logic [2:0] C_PC_FWD_DATA = 3'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [31:0] r_inst_id;
    logic [31:0] r_pc_id;
    logic        r_if_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_id_plus4;
    logic [31:0] w_br_off;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_id_plus4 = r_pc_id + 32'd4;
    assign w_br_off      = {{14{r_inst_id[15]}}, r_inst_id[15:0], 2'b00};

    // Redirects are only honoured for a live instruction that ID is consuming.
    assign w_redirect = if_en && r_if_valid &&
                        ((pc_src == C_PC_JUMP) || (pc_src == C_PC_BRANCH) ||
                         (pc_src == C_PC_FWD_DATA));

    always_comb begin
        w_target = w_pc_plus4;
        case (pc_src)
            C_PC_JUMP:     w_target = {w_pc_id_plus4[31:28], r_inst_id[25:0], 2'b00};
            C_PC_BRANCH:   w_target = w_pc_id_plus4 + w_br_off;
            C_PC_FWD_DATA: w_target = {fwd_rs_data[31:2], 2'b00};
            default:       w_target = w_pc_plus4;
        endcase
    end

    assign imem.imem_req  = !rst && ((r_state == S_FETCH) || (r_state == S_DROP));
    assign imem.imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign fetch_stall    = (r_state == S_FETCH) && imem.imem_req && !imem.imem_ack;

    assign inst_id  = r_inst_id;
    assign pc_id    = r_pc_id;
    assign if_valid = r_if_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_drop_addr <= 32'd0;
            r_inst_id   <= 32'd0;
            r_pc_id     <= 32'd0;
            r_if_valid  <= 1'b0;
            r_skid_inst <= 32'd0;
            r_skid_pc   <= 32'd0;
        end else if (if_rst) begin
            r_pc        <= RESET_PC;
            r_inst_id   <= 32'd0;
            r_pc_id     <= 32'd0;
            r_if_valid  <= 1'b0;
            r_skid_inst <= 32'd0;
            r_skid_pc   <= 32'd0;
            // An unanswered request must still be drained before fetching again.
            if ((r_state != S_HOLD) && !imem.imem_ack) begin
                r_state <= S_DROP;
                if (r_state == S_FETCH)
                    r_drop_addr <= r_pc;
            end else begin
                r_state <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_redirect) begin
                        r_pc       <= w_target;
                        r_if_valid <= 1'b0;
                        if (!imem.imem_ack) begin
                            r_drop_addr <= r_pc;
                            r_state     <= S_DROP;
                        end
                    end else if (imem.imem_ack) begin
                        r_pc <= w_pc_plus4;
                        if (if_en) begin
                            r_inst_id  <= imem.imem_rdata;
                            r_pc_id    <= r_pc;
                            r_if_valid <= 1'b1;
                        end else begin
                            r_skid_inst <= imem.imem_rdata;
                            r_skid_pc   <= r_pc;
                            r_state     <= S_HOLD;
                        end
                    end else if (if_en) begin
                        r_if_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_redirect) begin
                        r_pc       <= w_target;
                        r_if_valid <= 1'b0;
                        r_state    <= S_FETCH;
                    end else if (if_en) begin
                        r_inst_id  <= r_skid_inst;
                        r_pc_id    <= r_skid_pc;
                        r_if_valid <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_DROP: begin
                    r_if_valid <= 1'b0;
                    if (imem.imem_ack)
                        r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed-vector bench for if_fetch_unit with hand-computed values.
// Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;
    logic        clk;
    logic        rst;
    logic        if_rst;
    logic        if_en;
    logic [2:0]  pc_src;
    logic [31:0] fwd_rs_data;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic        if_valid;
    logic        fetch_stall;

    int n_tests;
    int n_fail;

    if_fetch_unit_if imem();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_rst      (if_rst),
        .if_en       (if_en),
        .pc_src      (pc_src),
        .fwd_rs_data (fwd_rs_data),
        .imem        (imem.master),
        .inst_id     (inst_id),
        .pc_id       (pc_id),
        .if_valid    (if_valid),
        .fetch_stall (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word at 8 is a beq with imm -2; every other word is a j-format with field addr+0x40.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [23:0] low;
        low = a[23:0] + 24'h40;
        return (a == 32'd8) ? 32'h1000_FFFE : {8'h08, low};
    endfunction

    assign imem.imem_rdata = mem_word(imem.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; if_rst = 1'b0; if_en = 1'b1; pc_src = 3'd0;
        fwd_rs_data = 32'd0; imem.imem_ack = 1'b1;

        tick(); tick();
        check("rst_req",     {31'd0, imem.imem_req}, 32'd0);
        check("rst_valid",   {31'd0, if_valid},      32'd0);
        check("rst_pc_id",   pc_id,                  32'd0);
        check("rst_inst_id", inst_id,                32'd0);
        rst = 1'b0; #1;
        check("seq_addr0", imem.imem_addr, 32'h0);
        check("seq_req0",  {31'd0, imem.imem_req}, 32'd1);

        tick(); // E1
        check("seq_pcid0",  pc_id, 32'h0);
        check("seq_valid0", {31'd0, if_valid}, 32'd1);
        check("seq_inst0",  inst_id, 32'h0800_0040);
        check("seq_addr4",  imem.imem_addr, 32'h4);
        tick(); // E2
        check("seq_pcid4",  pc_id, 32'h4);
        check("seq_addr8",  imem.imem_addr, 32'h8);
        tick(); // E3
        check("seq_pcid8",  pc_id, 32'h8);
        check("seq_beq",    inst_id, 32'h1000_FFFE);
        check("seq_addr12", imem.imem_addr, 32'hC);
        pc_src = 3'd2;

        tick(); // E4: branch taken back to 4
        pc_src = 3'd0;
        check("br_addr",  imem.imem_addr, 32'h4);
        check("br_valid", {31'd0, if_valid}, 32'd0);
        tick(); // E5
        check("br_pcid",   pc_id, 32'h4);
        check("br_valid1", {31'd0, if_valid}, 32'd1);
        check("br_addr8",  imem.imem_addr, 32'h8);

        tick(); // E6: addr 12 outstanding, JR during the wait
        imem.imem_ack = 1'b0; pc_src = 3'd3; fwd_rs_data = 32'h103; #1;
        check("jr_addr_wait", imem.imem_addr, 32'hC);
        check("jr_stall",     {31'd0, fetch_stall}, 32'd1);
        tick(); // E7: now in DROP
        pc_src = 3'd0; #1;
        check("drop_addr",  imem.imem_addr, 32'hC);
        check("drop_req",   {31'd0, imem.imem_req}, 32'd1);
        check("drop_valid", {31'd0, if_valid}, 32'd0);
        check("drop_stall", {31'd0, fetch_stall}, 32'd0);
        tick(); // E8
        imem.imem_ack = 1'b1; #1;
        check("drop_addr2", imem.imem_addr, 32'hC);
        tick(); // E9
        check("jr_addr",  imem.imem_addr, 32'h100);
        check("jr_valid", {31'd0, if_valid}, 32'd0);
        tick(); // E10
        check("jr_pcid",   pc_id, 32'h100);
        check("jr_valid1", {31'd0, if_valid}, 32'd1);
        pc_src = 3'd3; fwd_rs_data = 32'h10;

        tick(); // E11: at 16, stall ID
        pc_src = 3'd0; if_en = 1'b0;
        check("hold_addr16", imem.imem_addr, 32'h10);
        tick(); // E12
        check("hold_req",   {31'd0, imem.imem_req}, 32'd0);
        check("hold_valid", {31'd0, if_valid}, 32'd0);
        tick(); // E13
        check("hold_req2", {31'd0, imem.imem_req}, 32'd0);
        if_en = 1'b1;
        tick(); // E14
        check("hold_inst",  inst_id, 32'h0800_0050);
        check("hold_pcid",  pc_id, 32'h10);
        check("hold_valid1",{31'd0, if_valid}, 32'd1);
        check("hold_addr20",imem.imem_addr, 32'h14);
        pc_src = 3'd3; fwd_rs_data = 32'hFFFF_FFFF;

        tick(); // E15
        pc_src = 3'd0;
        check("wrap_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
        tick(); // E16
        check("wrap_addr0", imem.imem_addr, 32'h0);
        check("wrap_pcid",  pc_id, 32'hFFFF_FFFC);
        pc_src = 3'd3; fwd_rs_data = 32'h28;

        tick(); // E17: addr 40, ack withheld
        pc_src = 3'd0; imem.imem_ack = 1'b0; #1;
        check("ifrst_addr40", imem.imem_addr, 32'h28);
        check("ifrst_stall",  {31'd0, fetch_stall}, 32'd1);
        tick(); // E18
        check("ifrst_bubble", {31'd0, if_valid}, 32'd0);
        if_rst = 1'b1;
        tick(); // E19
        if_rst = 1'b0; #1;
        check("ifrst_drop_addr", imem.imem_addr, 32'h28);
        check("ifrst_drop_req",  {31'd0, imem.imem_req}, 32'd1);
        check("ifrst_valid",     {31'd0, if_valid}, 32'd0);
        tick(); // E20
        imem.imem_ack = 1'b1; #1;
        check("ifrst_drop_addr2", imem.imem_addr, 32'h28);
        check("ifrst_valid2",     {31'd0, if_valid}, 32'd0);
        tick(); // E21
        check("ifrst_fetch_rst_pc", imem.imem_addr, 32'h0);
        check("ifrst_valid3",       {31'd0, if_valid}, 32'd0);
        if_en = 1'b0;

        tick(); // E22: word 0 parked in HOLD, then global reset
        check("rhold_req", {31'd0, imem.imem_req}, 32'd0);
        rst = 1'b1; #1;
        check("rst_req_hold", {31'd0, imem.imem_req}, 32'd0);
        tick(); // E23
        check("rhold_valid", {31'd0, if_valid}, 32'd0);
        rst = 1'b0; if_en = 1'b1; #1;
        check("rhold_addr", imem.imem_addr, 32'h0);
        tick(); // E24
        check("rhold_pcid",  pc_id, 32'h0);
        check("rhold_valid1",{31'd0, if_valid}, 32'd1);
        check("rhold_addr4", imem.imem_addr, 32'h4);
        pc_src = 3'd5;
        tick(); // E25: pc_src 5 behaves as PC_NEXT
        check("src5_addr", imem.imem_addr, 32'h8);
        check("src5_pcid", pc_id, 32'h4);
        pc_src = 3'd1;
        tick(); // E26: jump from inst 0x08000044 at pc 4
        pc_src = 3'd0;
        check("jmp_addr",  imem.imem_addr, 32'h110);
        check("jmp_valid", {31'd0, if_valid}, 32'd0);
        tick(); // E27
        check("jmp_pcid", pc_id, 32'h110);
        check("jmp_inst", inst_id, 32'h0800_0150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
